// File: rtl/fetch_pc_ctrl.sv
// PC register and instruction-fetch sequencer: memory wait states, load-use stalls,
// misprediction redirect/flush, and draining of a fetch made stale by a redirect.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      next_pc_in,
  input  logic [31:0]      redirect_pc,
  input  logic             misprediction,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic [CNT_W-1:0] mispredict_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StWaitMem, StDrain} state_e;

  state_e             r_state, w_state_d;
  logic [31:0]        r_pc, w_pc_d;
  logic [31:0]        r_redir, w_redir_d;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_req, w_valid, w_flush, w_cnt_inc;

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_redir_d = r_redir;
    w_req     = 1'b0;
    w_valid   = 1'b0;
    w_flush   = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      StBoot: w_state_d = StRun;
      StRun, StWaitMem: begin
        if (misprediction) begin
          w_flush   = 1'b1;
          w_cnt_inc = 1'b1;
          if (r_state == StRun || imem_ready) begin
            w_pc_d    = redirect_pc;
            w_state_d = StRun;
          end else begin
            // Request already outstanding: keep the address stable until it returns.
            w_redir_d = redirect_pc;
            w_state_d = StDrain;
          end
        end else if (!hazard_stall) begin
          w_req = 1'b1;
          if (imem_ready) begin
            w_valid   = 1'b1;
            w_pc_d    = next_pc_in;
            w_state_d = StRun;
          end else begin
            w_state_d = StWaitMem;
          end
        end
      end
      StDrain: begin
        w_req = 1'b1;
        if (misprediction) begin
          w_flush   = 1'b1;
          w_cnt_inc = 1'b1;
          w_redir_d = redirect_pc;
        end
        if (imem_ready) begin
          w_pc_d    = misprediction ? redirect_pc : r_redir;
          w_state_d = StRun;
        end
      end
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StBoot;
      r_pc    <= RESET_PC;
      r_redir <= RESET_PC;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_redir <= w_redir_d;
      if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign imem_req       = w_req & ~rst;
  assign fetch_valid    = w_valid & ~rst;
  assign if_id_flush    = w_flush & ~rst;
  assign id_exe_flush   = w_flush & ~rst;
  assign imem_addr      = r_pc;
  assign pc             = r_pc;
  assign mispredict_cnt = r_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: table of per-cycle vectors plus hand sequences for
// WAIT_MEM/DRAIN redirects, counter saturation (second instance, CNT_W=2) and reset.
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] next_pc_in, redirect_pc;
  logic        misprediction, hazard_stall, imem_ready;
  logic        imem_req, fetch_valid, if_id_flush, id_exe_flush;
  logic [31:0] imem_addr, pc;
  logic [15:0] mispredict_cnt;
  logic        imem_req2, fetch_valid2, if_id_flush2, id_exe_flush2;
  logic [31:0] imem_addr2, pc2;
  logic [1:0]  mispredict_cnt2;

  int checks   = 0;
  int failures = 0;

  fetch_pc_ctrl #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .next_pc_in(next_pc_in), .redirect_pc(redirect_pc),
    .misprediction(misprediction), .hazard_stall(hazard_stall), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .fetch_valid(fetch_valid),
    .if_id_flush(if_id_flush), .id_exe_flush(id_exe_flush), .mispredict_cnt(mispredict_cnt)
  );

  fetch_pc_ctrl #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .next_pc_in(next_pc_in), .redirect_pc(redirect_pc),
    .misprediction(misprediction), .hazard_stall(hazard_stall), .imem_ready(imem_ready),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .pc(pc2), .fetch_valid(fetch_valid2),
    .if_id_flush(if_id_flush2), .id_exe_flush(id_exe_flush2),
    .mispredict_cnt(mispredict_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] np;
    logic [31:0] rd;
    logic        m;
    logic        s;
    logic        rdy;
    logic        e_req;
    logic        e_val;
    logic        e_fl;
    logic [31:0] e_pc;
    int          e_cnt;
  } vec_t;

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic cyc(input int id, input vec_t v);
    int sat;
    rst = v.rst; next_pc_in = v.np; redirect_pc = v.rd;
    misprediction = v.m; hazard_stall = v.s; imem_ready = v.rdy;
    #3;
    sat = (v.e_cnt > 3) ? 3 : v.e_cnt;
    chk("imem_req",     id, {31'b0, imem_req},     {31'b0, v.e_req});
    chk("fetch_valid",  id, {31'b0, fetch_valid},  {31'b0, v.e_val});
    chk("if_id_flush",  id, {31'b0, if_id_flush},  {31'b0, v.e_fl});
    chk("id_exe_flush", id, {31'b0, id_exe_flush}, {31'b0, v.e_fl});
    chk("pc",           id, pc,                    v.e_pc);
    chk("imem_addr",    id, imem_addr,             v.e_pc);
    chk("cnt",          id, {16'b0, mispredict_cnt}, v.e_cnt);
    chk("cnt_sat",      id, {30'b0, mispredict_cnt2}, sat);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] np, input logic [31:0] rd,
                              input logic m, input logic s, input logic rdy,
                              input logic ereq, input logic eval, input logic efl,
                              input logic [31:0] epc, input int ecnt);
    vec_t v;
    v.rst = r; v.np = np; v.rd = rd; v.m = m; v.s = s; v.rdy = rdy;
    v.e_req = ereq; v.e_val = eval; v.e_fl = efl; v.e_pc = epc; v.e_cnt = ecnt;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    //            rst  next_pc   redirect  m  s  rdy req val fl  pc        cnt
    tbl[0]  = mk(1, 32'h004, 32'h000, 0, 0, 1, 0, 0, 0, 32'h000, 0);  // in reset
    tbl[1]  = mk(0, 32'h004, 32'h000, 0, 0, 1, 0, 0, 0, 32'h000, 0);  // BOOT
    tbl[2]  = mk(0, 32'h004, 32'h000, 0, 0, 1, 1, 1, 0, 32'h000, 0);
    tbl[3]  = mk(0, 32'h008, 32'h000, 0, 0, 1, 1, 1, 0, 32'h004, 0);
    tbl[4]  = mk(0, 32'h00C, 32'h000, 0, 0, 1, 1, 1, 0, 32'h008, 0);
    tbl[5]  = mk(0, 32'h010, 32'h000, 0, 0, 1, 1, 1, 0, 32'h00C, 0);
    tbl[6]  = mk(0, 32'h014, 32'h000, 0, 0, 0, 1, 0, 0, 32'h010, 0);  // wait states
    tbl[7]  = mk(0, 32'h014, 32'h000, 0, 0, 0, 1, 0, 0, 32'h010, 0);
    tbl[8]  = mk(0, 32'h014, 32'h000, 0, 0, 0, 1, 0, 0, 32'h010, 0);
    tbl[9]  = mk(0, 32'h014, 32'h000, 0, 0, 1, 1, 1, 0, 32'h010, 0);
    tbl[10] = mk(0, 32'h018, 32'h200, 1, 0, 1, 0, 0, 1, 32'h014, 0);  // mispredict in RUN
    tbl[11] = mk(0, 32'h204, 32'h000, 0, 0, 1, 1, 1, 0, 32'h200, 1);
    tbl[12] = mk(0, 32'h208, 32'h040, 1, 1, 1, 0, 0, 1, 32'h204, 1);  // stall + mispredict
    tbl[13] = mk(0, 32'h044, 32'h000, 0, 1, 1, 0, 0, 0, 32'h040, 2);  // stall alone
    tbl[14] = mk(0, 32'h044, 32'h000, 0, 1, 1, 0, 0, 0, 32'h040, 2);
    tbl[15] = mk(0, 32'h044, 32'h000, 0, 0, 1, 1, 1, 0, 32'h040, 2);

    rst = 1'b1; next_pc_in = '0; redirect_pc = '0;
    misprediction = 1'b0; hazard_stall = 1'b0; imem_ready = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) cyc(i, tbl[i]);

    // Mispredict in WAIT_MEM -> DRAIN; stall ignored there; returned word dropped.
    cyc(100, mk(0, 32'h048, 32'h000, 0, 0, 0, 1, 0, 0, 32'h044, 2));
    cyc(101, mk(0, 32'h048, 32'h300, 1, 0, 0, 0, 0, 1, 32'h044, 2));
    cyc(102, mk(0, 32'h048, 32'h000, 0, 1, 0, 1, 0, 0, 32'h044, 3));
    cyc(103, mk(0, 32'h048, 32'h000, 0, 0, 1, 1, 0, 0, 32'h044, 3));
    cyc(104, mk(0, 32'h304, 32'h000, 0, 0, 1, 1, 1, 0, 32'h300, 3));

    // Second mispredict in DRAIN overwrites the stored redirect (600, not 500).
    cyc(110, mk(0, 32'h308, 32'h000, 0, 0, 0, 1, 0, 0, 32'h304, 3));
    cyc(111, mk(0, 32'h308, 32'h500, 1, 0, 0, 0, 0, 1, 32'h304, 3));
    cyc(112, mk(0, 32'h308, 32'h600, 1, 0, 0, 1, 0, 1, 32'h304, 4));
    cyc(113, mk(0, 32'h308, 32'h000, 0, 1, 0, 1, 0, 0, 32'h304, 5));
    cyc(114, mk(0, 32'h308, 32'h000, 0, 0, 1, 1, 0, 0, 32'h304, 5));
    cyc(115, mk(0, 32'h604, 32'h000, 0, 0, 0, 1, 0, 0, 32'h600, 5));

    // Enter DRAIN again, then reset mid-DRAIN.
    cyc(120, mk(0, 32'h604, 32'h700, 1, 0, 0, 0, 0, 1, 32'h600, 5));
    cyc(121, mk(1, 32'h604, 32'h000, 0, 0, 0, 0, 0, 0, 32'h600, 6));
    cyc(122, mk(0, 32'h004, 32'h000, 1, 0, 1, 0, 0, 0, 32'h000, 0));  // BOOT ignores m
    cyc(123, mk(0, 32'h004, 32'h000, 0, 0, 1, 1, 1, 0, 32'h000, 0));
    cyc(124, mk(0, 32'h008, 32'h000, 0, 0, 1, 1, 1, 0, 32'h004, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Owns the architectural PC register and sequences instruction fetch from the instruction memory port.
- Each cycle it selects between the next-PC value computed by the PC-select logic and the redirect (fallback) PC on a branch misprediction.
- Handles memory wait states, load-use hazard stalls and pipeline flush generation.
- Drains an in-flight fetch that a redirect has made stale.
- Sits between the next-PC select logic, the instruction memory and the IF/ID and ID/EXE pipeline registers.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- CNT_W, 16, width of the saturating misprediction counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- next_pc_in  in  32  sequential or predicted next PC from PC-select logic (PC+4, branch fall-through, jal or jalr target).
- redirect_pc  in  32  ID/EXE fallback PC, used on misprediction.
- misprediction  in  1  branch resolved in EXE against the prediction.
- hazard_stall  in  1  load-use stall request from the hazard unit.
- imem_ready  in  1  instruction memory has data for the presented address this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equal to pc.
- pc  out  32  current PC register.
- fetch_valid  out  1  instruction word accepted this cycle; IF/ID may load.
- if_id_flush  out  1  load NOP into IF/ID.
- id_exe_flush  out  1  load NOP into ID/EXE.
- mispredict_cnt  out  CNT_W  saturating count of mispredictions.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - pc = RESET_PC; state = BOOT; mispredict_cnt = 0.
  - imem_req = 0, fetch_valid = 0, flush outputs = 0 during reset.
  - rst asserted in any state overrides everything at the next edge.
- States: BOOT, RUN, WAIT_MEM, DRAIN.
- BOOT:
  - imem_req = 0; lasts exactly one cycle after rst deasserts, then RUN.
  - misprediction is ignored in BOOT.
- imem_req = 1 in RUN and WAIT_MEM when hazard_stall = 0 and misprediction = 0. Otherwise imem_req = 0.
- imem_req = 1 in DRAIN, so the outstanding request is held until imem_ready.
- Fetch completes when imem_req = 1 and imem_ready = 1 in RUN or WAIT_MEM:
  - fetch_valid = 1 (combinational, same cycle).
  - pc <= next_pc_in; state <= RUN.
- In RUN or WAIT_MEM, imem_req = 1 and imem_ready = 0: pc holds; state <= WAIT_MEM; fetch_valid = 0.
- hazard_stall = 1 with misprediction = 0: pc and state hold; imem_req = 0; fetch_valid = 0; no flush.
- A stall arriving in WAIT_MEM deasserts imem_req. The memory must treat this as request withdrawal; the request is re-issued when the stall drops.
- Misprediction has highest priority after rst, in RUN, WAIT_MEM or DRAIN:
  - if_id_flush = id_exe_flush = 1 combinationally in that cycle.
  - fetch_valid = 0; any data returned that cycle is discarded.
  - mispredict_cnt increments, saturating at all-ones (no wrap).
  - From RUN, or from WAIT_MEM with imem_ready = 1: pc <= redirect_pc; state <= RUN.
  - From WAIT_MEM with imem_ready = 0: redirect_pc is stored in an internal redirect register; state <= DRAIN; pc holds so that imem_addr stays stable.
- DRAIN:
  - imem_req = 1, fetch_valid = 0.
  - On imem_ready = 1: data is dropped, pc <= stored redirect, state <= RUN.
  - A new misprediction while in DRAIN overwrites the stored redirect and flushes again; remains DRAIN unless imem_ready = 1.
  - hazard_stall is ignored in DRAIN.
- Simultaneous hazard_stall and misprediction: misprediction wins.
- pc is never changed except through these rules.
- No arithmetic is done on the PC; the block does not enforce alignment.

Test Plan:
- Reset then run, with imem_ready held 1 and next_pc_in = pc+4: one BOOT cycle, then fetch_valid every cycle; pc = 0x0, 0x4, 0x8, 0xC.
- imem_ready low for 3 cycles at pc = 0x10: imem_addr stays 0x10, fetch_valid stays 0, state is WAIT_MEM; on ready, fetch_valid = 1 and pc becomes 0x14.
- Misprediction in RUN with redirect_pc = 0x200: both flushes = 1 that cycle; fetch_valid = 0; next pc = 0x200; mispredict_cnt = 1.
- Misprediction in WAIT_MEM (redirect 0x300), then ready after 2 cycles: DRAIN held, the returned word is dropped with fetch_valid = 0, then pc = 0x300 and state is RUN.
- hazard_stall and misprediction together (redirect 0x40): the redirect is taken; hazard_stall alone for 2 cycles then holds pc with imem_req = 0.
- CNT_W = 2 with 5 mispredictions: mispredict_cnt = 3 (saturated); rst asserted mid-DRAIN gives pc = RESET_PC, state BOOT and count 0.
